// File: rtl/oscillo_pkg.sv
// rtl/oscillo_pkg.sv - shared types and constants for the triggered capture engine
// Contents: capture FSM state enum, trigger mode codes, slope codes.
package oscillo_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFILL,
        ST_WAIT_TRIG,
        ST_POSTFILL,
        ST_READOUT
    } state_t;

    // Mode 3 is reserved and behaves like TRIG_NORMAL.
    localparam logic [1:0] TRIG_NORMAL = 2'd0;
    localparam logic [1:0] TRIG_AUTO   = 2'd1;
    localparam logic [1:0] TRIG_FORCE  = 2'd2;

    localparam logic SLOPE_RISING  = 1'b0;
    localparam logic SLOPE_FALLING = 1'b1;

endpackage

// File: rtl/capture_ram.sv
// rtl/capture_ram.sv - simple dual-port sample RAM with registered read
// Ports: clk; write port we/waddr/wdata; read port re/raddr, rdata valid one
// cycle after re. Contents are never cleared.
module capture_ram #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/oscillo_trig_capture.sv
// rtl/oscillo_trig_capture.sv - triggered multi-channel waveform capture with stream readout
// Ports: clk, rst (sync, active high); arm plus trigger configuration
// (trig_mode, trig_slope, trig_level, trig_ch, pretrig) latched on an accepted
// arm; din_valid/din sample input; rd_data/rd_valid/rd_ready/rd_last readout
// stream; busy, triggered and done status.
module oscillo_trig_capture
    import oscillo_pkg::*;
#(
    parameter int SAMPLE_W     = 8,
    parameter int ADDR_W       = 9,
    parameter int NCH          = 1,
    parameter int AUTO_TIMEOUT = 1024
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   arm,
    input  logic [1:0]                             trig_mode,
    input  logic                                   trig_slope,
    input  logic [SAMPLE_W-1:0]                    trig_level,
    input  logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] trig_ch,
    input  logic [ADDR_W-1:0]                      pretrig,
    input  logic                                   din_valid,
    input  logic [NCH*SAMPLE_W-1:0]                din,
    output logic [SAMPLE_W-1:0]                    rd_data,
    output logic                                   rd_valid,
    input  logic                                   rd_ready,
    output logic                                   rd_last,
    output logic                                   busy,
    output logic                                   triggered,
    output logic                                   done
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CHW   = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int TW    = $clog2(AUTO_TIMEOUT + 1);
    localparam int NW    = $clog2(DEPTH * NCH + 1);

    state_t              state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W:0]     cnt;
    logic [TW-1:0]       auto_cnt;
    logic [1:0]          mode_q;
    logic                slope_q;
    logic [SAMPLE_W-1:0] level_q;
    logic [CHW-1:0]      ch_q;
    logic [ADDR_W-1:0]   pre_q;
    logic [SAMPLE_W-1:0] prev_q;
    logic                have_prev;

    logic [ADDR_W-1:0]   rd_addr;
    logic [CHW-1:0]      rd_ch;
    logic [CHW-1:0]      sel_ch;
    logic [NW-1:0]       issue_cnt;
    logic                pending;
    logic                pend_last;

    logic [SAMPLE_W-1:0] ram_q [NCH];
    logic [SAMPLE_W-1:0] cur;
    logic [SAMPLE_W-1:0] rd_word;
    logic                wr_en;
    logic                rd_en;
    logic                edge_hit;
    logic                fire;
    logic [ADDR_W:0]     post_target;

    assign busy = (state != ST_IDLE);

    always_comb begin
        cur = din[SAMPLE_W-1:0];
        for (int c = 0; c < NCH; c++) begin
            if (ch_q == CHW'(c)) begin
                cur = din[c*SAMPLE_W +: SAMPLE_W];
            end
        end
        rd_word = ram_q[0];
        for (int c = 0; c < NCH; c++) begin
            if (sel_ch == CHW'(c)) begin
                rd_word = ram_q[c];
            end
        end
    end

    assign wr_en = din_valid && (state == ST_PREFILL || state == ST_WAIT_TRIG ||
                                 state == ST_POSTFILL);

    // Edges need a previous sample of this capture; PREFILL samples count.
    assign edge_hit = have_prev &&
        ((slope_q == SLOPE_RISING) ? (prev_q < level_q && cur >= level_q)
                                   : (prev_q >= level_q && cur < level_q));

    always_comb begin
        case (mode_q)
            TRIG_FORCE: fire = 1'b1;
            TRIG_AUTO:  fire = edge_hit || (auto_cnt == TW'(AUTO_TIMEOUT - 1));
            default:    fire = edge_hit;
        endcase
    end

    // Samples from the trigger (inclusive) to the end of the frame.
    assign post_target = (ADDR_W+1)'(DEPTH) - {1'b0, pre_q};

    // A read is issued only when the output register is free (or being
    // drained) and no read is in flight, so the stream holds under stall.
    assign rd_en = (state == ST_READOUT) && !pending && (!rd_valid || rd_ready) &&
                   (issue_cnt != NW'(DEPTH * NCH));

    for (genvar g = 0; g < NCH; g++) begin : g_ram
        capture_ram #(
            .ADDR_W (ADDR_W),
            .DATA_W (SAMPLE_W)
        ) u_ram (
            .clk   (clk),
            .we    (wr_en),
            .waddr (wr_ptr),
            .wdata (din[g*SAMPLE_W +: SAMPLE_W]),
            .re    (rd_en),
            .raddr (rd_addr),
            .rdata (ram_q[g])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            wr_ptr    <= '0;
            cnt       <= '0;
            auto_cnt  <= '0;
            mode_q    <= TRIG_NORMAL;
            slope_q   <= SLOPE_RISING;
            level_q   <= '0;
            ch_q      <= '0;
            pre_q     <= '0;
            prev_q    <= '0;
            have_prev <= 1'b0;
            rd_addr   <= '0;
            rd_ch     <= '0;
            sel_ch    <= '0;
            issue_cnt <= '0;
            pending   <= 1'b0;
            pend_last <= 1'b0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            rd_last   <= 1'b0;
            triggered <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en) begin
                wr_ptr    <= wr_ptr + 1'b1;
                prev_q    <= cur;
                have_prev <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (arm) begin
                        mode_q    <= trig_mode;
                        slope_q   <= trig_slope;
                        level_q   <= trig_level;
                        ch_q      <= trig_ch;
                        pre_q     <= pretrig;
                        triggered <= 1'b0;
                        cnt       <= '0;
                        auto_cnt  <= '0;
                        have_prev <= 1'b0;
                        rd_ch     <= '0;
                        issue_cnt <= '0;
                        state     <= (pretrig == '0) ? ST_WAIT_TRIG : ST_PREFILL;
                    end
                end
                ST_PREFILL: begin
                    if (din_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == {1'b0, pre_q}) begin
                            state <= ST_WAIT_TRIG;
                        end
                    end
                end
                ST_WAIT_TRIG: begin
                    if (din_valid) begin
                        auto_cnt <= auto_cnt + 1'b1;
                        if (fire) begin
                            triggered <= 1'b1;
                            cnt       <= (ADDR_W+1)'(1);
                            if (post_target == (ADDR_W+1)'(1)) begin
                                // The next write pointer is trig_addr - pretrig.
                                rd_addr <= wr_ptr + 1'b1;
                                state   <= ST_READOUT;
                            end else begin
                                state <= ST_POSTFILL;
                            end
                        end
                    end
                end
                ST_POSTFILL: begin
                    if (din_valid) begin
                        cnt <= cnt + 1'b1;
                        if (cnt + 1'b1 == post_target) begin
                            // After a full frame the next write pointer is
                            // the oldest sample, i.e. trig_addr - pretrig.
                            rd_addr <= wr_ptr + 1'b1;
                            state   <= ST_READOUT;
                        end
                    end
                end
                ST_READOUT: begin
                    if (rd_valid && rd_ready) begin
                        rd_valid <= 1'b0;
                        rd_last  <= 1'b0;
                        if (rd_last) begin
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    if (pending) begin
                        rd_data   <= rd_word;
                        rd_valid  <= 1'b1;
                        rd_last   <= pend_last;
                        pending   <= 1'b0;
                    end else if (rd_en) begin
                        pending   <= 1'b1;
                        sel_ch    <= rd_ch;
                        pend_last <= (issue_cnt == NW'(DEPTH * NCH - 1));
                        issue_cnt <= issue_cnt + 1'b1;
                        if (rd_ch == CHW'(NCH - 1)) begin
                            rd_ch   <= '0;
                            rd_addr <= rd_addr + 1'b1;
                        end else begin
                            rd_ch <= rd_ch + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oscillo_trig_capture.sv
// tb/tb_oscillo_trig_capture.sv - randomized self-checking bench for oscillo_trig_capture
module tb_oscillo_trig_capture;

    localparam int SW     = 8;
    localparam int AW     = 4;
    localparam int NCH    = 2;
    localparam int AT     = 8;
    localparam int DEPTH  = 2**AW;
    localparam int NWORDS = DEPTH * NCH;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            arm = 1'b0;
    logic [1:0]      trig_mode = 2'd0;
    logic            trig_slope = 1'b0;
    logic [SW-1:0]   trig_level = '0;
    logic [0:0]      trig_ch = '0;
    logic [AW-1:0]   pretrig = '0;
    logic            din_valid = 1'b0;
    logic [NCH*SW-1:0] din = '0;
    logic [SW-1:0]   rd_data;
    logic            rd_valid;
    logic            rd_ready = 1'b0;
    logic            rd_last;
    logic            busy;
    logic            triggered;
    logic            done;

    always #5 clk = ~clk;

    oscillo_trig_capture #(
        .SAMPLE_W     (SW),
        .ADDR_W       (AW),
        .NCH          (NCH),
        .AUTO_TIMEOUT (AT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .arm        (arm),
        .trig_mode  (trig_mode),
        .trig_slope (trig_slope),
        .trig_level (trig_level),
        .trig_ch    (trig_ch),
        .pretrig    (pretrig),
        .din_valid  (din_valid),
        .din        (din),
        .rd_data    (rd_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_last    (rd_last),
        .busy       (busy),
        .triggered  (triggered),
        .done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Behavioural model: every valid sample since arm is kept; the trigger
    // is located by the rules, and the frame is the DEPTH samples starting
    // pretrig before the trigger, channels interleaved.
    logic [NCH*SW-1:0] smp [$];
    logic [SW-1:0]     expq [$];
    int trig_idx;
    int m_pre, m_mode, m_slope, m_level, m_ch;

    function automatic int chv(input logic [NCH*SW-1:0] v, input int c);
        return int'(v[c*SW +: SW]);
    endfunction

    task automatic model_push(input logic [NCH*SW-1:0] v, output bit complete);
        int  n, j, cur, p;
        bit  edge_ok, fire;
        smp.push_back(v);
        n = smp.size() - 1;
        complete = 1'b0;
        if (trig_idx < 0 && n >= m_pre) begin
            j = n - m_pre;
            cur = chv(v, m_ch);
            edge_ok = 1'b0;
            if (n >= 1) begin
                p = chv(smp[n-1], m_ch);
                if (m_slope == 0) edge_ok = (p < m_level) && (cur >= m_level);
                else              edge_ok = (p >= m_level) && (cur < m_level);
            end
            if (m_mode == 2)      fire = (j == 0);
            else if (m_mode == 1) fire = edge_ok || (j == AT - 1);
            else                  fire = edge_ok;
            if (fire) trig_idx = n;
        end
        if (trig_idx >= 0 && n - trig_idx + 1 == DEPTH - m_pre) begin
            complete = 1'b1;
            for (int i = trig_idx - m_pre; i < trig_idx - m_pre + DEPTH; i++)
                for (int c = 0; c < NCH; c++)
                    expq.push_back(SW'(chv(smp[i], c)));
        end
    endtask

    function automatic logic [NCH*SW-1:0] gen(input int kind, input int n);
        logic [SW-1:0] a, b;
        logic [7:0] nb;
        nb = 8'(n);
        case (kind)
            0: begin a = nb;               b = 8'hA5 ^ nb; end
            1: begin a = 8'h11;            b = 8'hFF - nb; end
            2: begin a = 8'h00;            b = 8'h00; end
            4: begin a = (n < 18) ? SW'($urandom_range(127)) : SW'($urandom_range(255, 128));
                     b = SW'($urandom); end
            default: begin a = SW'($urandom); b = SW'($urandom); end
        endcase
        return {b, a};
    endfunction

    // Output compare process: every cycle with rd_valid is checked against
    // the model queue; stalls must hold; done must pulse exactly once.
    bit       exp_done   = 1'b0;
    bit       was_stall  = 1'b0;
    bit       prev_rst   = 1'b1;
    logic [SW-1:0] last_data;
    logic     last_lastb;
    int       done_count = 0;

    always @(negedge clk) begin
        if (!prev_rst && !rst) begin
            check("done_pulse", 32'(done), 32'(exp_done));
            if (was_stall) begin
                check("hold_valid", 32'(rd_valid), 32'd1);
                check("hold_data", 32'(rd_data), 32'(last_data));
                check("hold_last", 32'(rd_last), 32'(last_lastb));
            end
        end
        if (done) done_count++;
        exp_done = 1'b0;
        if (rd_valid && !rst) begin
            if (expq.size() == 0) begin
                fail_now("unexpected_word");
            end else begin
                check("rd_data", 32'(rd_data), 32'(expq[0]));
                check("rd_last", 32'(rd_last), 32'(expq.size() == 1));
                if (rd_ready) begin
                    if (expq.size() == 1) exp_done = 1'b1;
                    void'(expq.pop_front());
                end
            end
        end
        was_stall  = rd_valid && !rd_ready && !rst;
        last_data  = rd_data;
        last_lastb = rd_last;
        prev_rst   = rst;
    end

    task automatic arm_cfg(input int mode, input int slope, input int level,
                           input int ch, input int pre);
        @(posedge clk); #1;
        trig_mode  = 2'(mode);
        trig_slope = 1'(slope);
        trig_level = SW'(level);
        trig_ch    = 1'(ch);
        pretrig    = AW'(pre);
        arm        = 1'b1;
        smp.delete();
        expq.delete();
        trig_idx = -1;
        m_mode = (mode == 3) ? 0 : mode;
        m_slope = slope; m_level = level; m_ch = ch; m_pre = pre;
        @(posedge clk); #1;
        arm = 1'b0;
        @(negedge clk);
        check("arm_busy", 32'(busy), 32'd1);
        check("arm_trig_clear", 32'(triggered), 32'd0);
    endtask

    task automatic run_capture(input int kind, input int pct, input int abort_after);
        bit complete, stop;
        int cycles;
        logic [NCH*SW-1:0] v;
        stop = 1'b0;
        cycles = 0;
        while (!stop && cycles < 3000) begin
            @(posedge clk); #1;
            cycles++;
            din_valid = ($urandom_range(99) < pct);
            din = NCH*SW'($urandom);
            if (din_valid) begin
                v = gen(kind, smp.size());
                din = v;
                model_push(v, complete);
                stop = complete ||
                       (abort_after > 0 && trig_idx >= 0 && (smp.size() - 1 - trig_idx) >= abort_after);
            end
        end
        @(posedge clk); #1;
        din_valid = 1'b0;
        if (!stop) fail_now("capture_timeout");
    endtask

    task automatic drain(input int rmode, input bit arm_mid);
        int cycles, first, dc0;
        cycles = 0;
        first = -1;
        dc0 = done_count;
        while ((expq.size() > 0 || done_count == dc0) && cycles < 2000) begin
            case (rmode)
                0: rd_ready = 1'b1;
                1: rd_ready = (cycles % 3 == 0);
                default: rd_ready = 1'($urandom);
            endcase
            arm = arm_mid && (cycles == 6);
            din_valid = 1'($urandom);
            din = NCH*SW'($urandom);
            @(negedge clk);
            cycles++;
            if (rd_valid && first < 0) first = cycles;
            @(posedge clk); #1;
        end
        arm = 1'b0;
        rd_ready = 1'b0;
        din_valid = 1'b0;
        if (cycles >= 2000) fail_now("drain_timeout");
        check("first_valid_within_3", 32'(first >= 1 && first <= 3), 32'd1);
        if (rmode == 0) check("throughput", 32'(cycles <= 2 * NWORDS + 4), 32'd1);
        check("done_once", 32'(done_count - dc0), 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("idle_after_frame", 32'(busy), 32'd0);
        check("triggered_sticky", 32'(triggered), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_triggered", 32'(triggered), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_rd_last", 32'(rd_last), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Ramp, rising through 0x80 with 4 pre-trigger samples.
        arm_cfg(0, 0, 8'h80, 0, 4);
        run_capture(0, 100, 0);
        check("pin_t1_len", 32'(expq.size()), 32'(NWORDS));
        check("pin_t1_first", 32'(expq[0]), 32'h7C);
        check("pin_t1_last_ch0", 32'(expq[NWORDS-2]), 32'h8B);
        drain(0, 1'b0);

        // Falling edge on channel 1, no pre-trigger.
        arm_cfg(0, 1, 8'h40, 1, 0);
        run_capture(1, 100, 0);
        check("pin_t2_ch0", 32'(expq[0]), 32'h11);
        check("pin_t2_first", 32'(expq[1]), 32'h3F);
        check("pin_t2_last", 32'(expq[NWORDS-1]), 32'h30);
        drain(0, 1'b0);

        // Auto timeout on a flat signal.
        arm_cfg(1, 0, 8'h80, 0, 2);
        run_capture(2, 70, 0);
        check("pin_t3_trig_idx", 32'(trig_idx), 32'd9);
        @(negedge clk);
        check("auto_triggered", 32'(triggered), 32'd1);
        drain(2, 1'b0);

        // Reset while in POSTFILL discards the frame.
        arm_cfg(2, 0, 0, 0, 4);
        run_capture(3, 70, 3);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        expq.delete();
        @(negedge clk);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_rd_valid", 32'(rd_valid), 32'd0);
        check("rst_mid_triggered", 32'(triggered), 32'd0);
        repeat (4) @(posedge clk);

        // Fresh capture after reset: wraps, trigger lands at address 2.
        arm_cfg(0, 0, 8'h80, 0, 15);
        run_capture(4, 50, 0);
        check("pin_t4_trig_idx", 32'(trig_idx), 32'd18);
        drain(2, 1'b0);

        // Backpressure, one ready cycle in three.
        arm_cfg(2, 0, 0, 1, 7);
        run_capture(3, 60, 0);
        drain(1, 1'b0);

        // Arm during READOUT is ignored.
        arm_cfg(1, 0, 8'h80, 0, 5);
        run_capture(3, 80, 0);
        drain(0, 1'b1);

        // Random configurations.
        for (int it = 0; it < 6; it++) begin
            arm_cfg($urandom_range(3), $urandom_range(1), $urandom_range(8'hE0, 8'h20),
                    $urandom_range(1), $urandom_range(DEPTH - 1));
            run_capture(3, $urandom_range(100, 30), 0);
            drain(2, 1'b0);
        end

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/oscillo_trig_capture.md
Name: oscillo_trig_capture

Overview:
- Parametrised, triggered waveform capture engine; the next generation of the single-shot 512-sample grabber.
- Samples NCH channels into circular RAM banks while armed, then detects a level/slope trigger on a selectable channel, keeping a programmable pre-trigger window.
- Replays the frame chronologically as a byte stream with valid/ready handshake, toward the UART transmitter.
- Sits between the ADC sample register and async_transmitter; single clock domain.

Parameters:
- SAMPLE_W, 8, bits per sample and per output word.
- ADDR_W, 9, log2 of frame depth; DEPTH = 2**ADDR_W samples per channel.
- NCH, 1, channel count, 1..4.
- AUTO_TIMEOUT, 1024, valid samples waited in WAIT_TRIG before an auto-mode forced trigger; must be >= 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle start pulse; honoured only in IDLE.
- trig_mode  in  2  0 normal, 1 auto, 2 force, 3 reserved (treated as normal).
- trig_slope  in  1  0 rising, 1 falling.
- trig_level  in  SAMPLE_W  unsigned threshold.
- trig_ch  in  max(1,$clog2(NCH))  trigger source channel.
- pretrig  in  ADDR_W  samples kept before the trigger sample.
- din_valid  in  1  sample strobe.
- din  in  NCH*SAMPLE_W  channel c at bits [c*SAMPLE_W +: SAMPLE_W].
- rd_data  out  SAMPLE_W  readout word.
- rd_valid  out  1  rd_data valid.
- rd_ready  in  1  consumer accepts.
- rd_last  out  1  marks the final word of a frame.
- busy  out  1  state != IDLE.
- triggered  out  1  trigger has occurred since the last arm.
- done  out  1  one-cycle pulse when the last word is accepted.

Behaviour:
- Reset: state=IDLE; busy, triggered, done, rd_valid, rd_last = 0; pointers = 0; RAM contents are not cleared.
- arm, trig_mode, trig_slope, trig_level, trig_ch and pretrig are latched on the accepted arm. arm is ignored when busy=1. triggered clears on an accepted arm.
- Writes occur only when din_valid=1 in PREFILL, WAIT_TRIG or POSTFILL: all channels are written to wr_ptr, then wr_ptr increments mod DEPTH (wraps).
- IDLE -> PREFILL on arm. If pretrig=0, IDLE -> WAIT_TRIG directly.
- PREFILL: count pretrig valid samples, then -> WAIT_TRIG. No trigger evaluation in PREFILL.
- WAIT_TRIG, for each valid sample cur on the selected channel, with prev = previous valid sample of that channel since arm, including PREFILL samples:
  - rising fires when prev < level and cur >= level; falling fires when prev >= level and cur < level.
  - No edge can fire on the first sample after arm (no prev yet).
  - force mode: the first valid sample in WAIT_TRIG fires.
  - auto mode: the AUTO_TIMEOUT-th valid sample in WAIT_TRIG fires unless a real edge fires earlier.
  - The firing sample is the trigger sample. It is written at trig_addr; set triggered=1; -> POSTFILL.
- POSTFILL: write until DEPTH-pretrig samples (trigger sample included) are written, then -> READOUT. frame_start = trig_addr - pretrig mod DEPTH.
- READOUT:
  - Emit DEPTH*NCH words: address frame_start, frame_start+1, ... (wrapping); at each address, channels 0..NCH-1. din is ignored.
  - RAM read latency is 1 cycle; the first rd_valid comes within 3 cycles of entering READOUT.
  - rd_data and rd_last must be held stable while rd_valid=1 and rd_ready=0.
  - Throughput is >= 1 word per 2 cycles with rd_ready held high.
  - rd_last=1 on the final word only. When that word is accepted: pulse done, -> IDLE; triggered stays 1.
- rst mid-operation: IDLE on the next cycle; an in-flight frame is discarded with no done pulse.

Decomposition:
- Package oscillo_pkg: state enum (IDLE, PREFILL, WAIT_TRIG, POSTFILL, READOUT), TRIG_NORMAL/AUTO/FORCE constants, slope constants.
- One sub-module, capture_ram: simple dual-port, 2**ADDR_W x SAMPLE_W, synchronous read, instantiated NCH times via generate; read enable from the readout stage.

Test Plan:
- NCH=1, ADDR_W=4, pretrig=4, rising, level=0x80, din=ramp 0x00,0x01,... every cycle -> trigger on 0x80; 16 words 0x7C..0x8B; rd_last on 0x8B; one done pulse.
- NCH=2, trig_ch=1, falling, level=0x40, pretrig=0, ch0=0x11, ch1 descending from 0xFF -> trigger at ch1=0x3F; 32 words 0x11,0x3F,0x11,0x3E,...,0x11,0x30.
- Auto mode, AUTO_TIMEOUT=8, pretrig=2, din constant 0x00 -> forced trigger on the 8th WAIT_TRIG sample; triggered=1; 16 words, all 0x00.
- Wrap plus gaps: pretrig=15, trigger written at address 2, din_valid 50% random -> frame_start=3; output is chronological with no gap artefacts.
- Backpressure: rd_ready high 1 cycle in 3 -> rd_data stable while stalled; every word exactly once, in order.
- Control: arm during READOUT -> ignored, frame completes. rst during POSTFILL -> busy=0 and rd_valid=0 next cycle, no done pulse. A fresh arm then captures correctly.
